// File: rtl/t05_sram_arbiter.sv
// t05_sram_arbiter: four-requester round-robin arbiter in front of a single-port SRAM.
// Only one transaction is outstanding at a time. The SRAM handshake is busy_o rising
// (access accepted), then busy_o falling (access done).
// Optional watchdog: define T05_ARB_TIMEOUT_EN to abort a stalled access after
// TIMEOUT_CYC cycles. The aborted access completes with err = 1 on its ack.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | SRAM side idle; arbitrate among req from ptr
// ISSUE     | one-cycle wr_en/r_en strobe with latched address/data
// WAIT_ACC  | strobes low; wait for busy_o to rise
// WAIT_DONE | wait for busy_o to fall; read data captured on that edge
// RESP      | one-cycle ack to the owner; ptr advances past the owner
module t05_sram_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [3:0]   req,
    input  logic [3:0]   req_we,
    input  logic [127:0] req_addr,
    input  logic [127:0] req_wdata,
    output logic [3:0]   gnt,
    output logic [3:0]   ack,
    output logic [31:0]  rdata,
    output logic         err,
    output logic         wr_en,
    output logic         r_en,
    output logic [3:0]   select,
    output logic [31:0]  addr,
    output logic [31:0]  data_i,
    input  logic         busy_o,
    input  logic [31:0]  data_o
);

    localparam logic [31:0] IDLE_ADDR = 32'h3300_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACC,
        WAIT_DONE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q;
    logic [1:0]  idx_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  gnt_q;
    logic [31:0] rdata_q;

    logic        win_found;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic        tmo;

    // Round-robin search: first asserted request at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a watchdog expiry short-circuits either wait state to RESP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (busy_o) begin
                    state_d = WAIT_DONE;
                end else if (tmo) begin
                    state_d = RESP;
                end
            end
            WAIT_DONE: begin
                if (!busy_o || tmo) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner's request on grant; release ownership and rotate ptr on RESP.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= IDLE_ADDR;
            wdata_q <= 32'd0;
            gnt_q   <= 4'd0;
        end else if (state_q == IDLE && win_found) begin
            idx_q   <= win_idx;
            we_q    <= req_we[win_idx];
            addr_q  <= req_addr[{win_idx, 5'd0} +: 32];
            wdata_q <= req_wdata[{win_idx, 5'd0} +: 32];
            gnt_q   <= 4'b0001 << win_idx;
        end else if (state_q == RESP) begin
            gnt_q   <= 4'd0;
            ptr_q   <= idx_q + 2'd1;
        end
    end

    // Read data is captured only on a genuine busy_o fall of a read; writes and timeouts leave it alone.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata_q <= 32'd0;
        end else if (state_q == WAIT_DONE && !busy_o && !we_q) begin
            rdata_q <= data_o;
        end
    end

`ifdef T05_ARB_TIMEOUT_EN
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYC - 1);

    logic [31:0] tmo_cnt_q;
    logic        in_wait;
    logic        stall;
    logic        err_q;

    assign in_wait = (state_q == WAIT_ACC) || (state_q == WAIT_DONE);
    assign stall   = ((state_q == WAIT_ACC) && !busy_o) ||
                     ((state_q == WAIT_DONE) && busy_o);
    assign tmo     = stall && (tmo_cnt_q == 32'd0);

    // Watchdog down-counter, reloaded on entry to each wait state; expiry at terminal count zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_cnt_q <= 32'd0;
        end else if ((state_d == WAIT_ACC || state_d == WAIT_DONE) && state_d != state_q) begin
            tmo_cnt_q <= TMO_LOAD;
        end else if (in_wait && tmo_cnt_q != 32'd0) begin
            tmo_cnt_q <= tmo_cnt_q - 32'd1;
        end
    end

    // err is raised for the RESP cycle that follows an expiry and dropped when RESP exits.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_q <= 1'b0;
        end else if (state_q == RESP) begin
            err_q <= 1'b0;
        end else if (tmo) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic [31:0] unused_tmo_cyc;

    assign unused_tmo_cyc = 32'(TIMEOUT_CYC);
    assign tmo            = 1'b0;
    assign err            = 1'b0;
`endif

    // SRAM-side outputs: idle values except while a transaction is on the bus.
    always_comb begin
        wr_en  = 1'b0;
        r_en   = 1'b0;
        select = 4'hF;
        addr   = IDLE_ADDR;
        data_i = 32'd0;
        unique case (state_q)
            ISSUE: begin
                addr   = addr_q;
                wr_en  = we_q;
                r_en   = !we_q;
                data_i = we_q ? wdata_q : 32'd0;
            end
            WAIT_ACC, WAIT_DONE: begin
                addr   = addr_q;
                data_i = we_q ? wdata_q : 32'd0;
            end
            default: begin
            end
        endcase
    end

    assign gnt   = gnt_q;
    assign ack   = (state_q == RESP) ? gnt_q : 4'd0;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_t05_sram_arbiter.sv
module tb_t05_sram_arbiter;

    logic         clk;
    logic         nrst;
    logic [3:0]   req;
    logic [3:0]   req_we;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   gnt;
    logic [3:0]   ack;
    logic [31:0]  rdata;
    logic         err;
    logic         wr_en;
    logic         r_en;
    logic [3:0]   select;
    logic [31:0]  addr;
    logic [31:0]  data_i;
    logic         busy_o;
    logic [31:0]  data_o;

    int n_total = 0;
    int n_pass  = 0;

    t05_sram_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .wr_en     (wr_en),
        .r_en      (r_en),
        .select    (select),
        .addr      (addr),
        .data_i    (data_i),
        .busy_o    (busy_o),
        .data_o    (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] sram;
        logic [3:0]  exp_gnt;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for an ISSUE strobe, play the SRAM handshake with minimum latency, check the ack cycle.
    task automatic service(input logic [31:0] val, output logic [3:0] g);
        bit seen;
        seen = 1'b0;
        g    = 4'd0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (wr_en || r_en) seen = 1'b1;
        end
        chk("issue_seen", {31'd0, seen}, 32'd1);
        if (!seen) return;
        g = gnt;
        @(posedge clk); #1 busy_o = 1'b1;
        @(posedge clk); #1 busy_o = 1'b0; data_o = val;
        @(negedge clk);
        chk("svc_no_early_ack", {28'd0, ack}, 32'd0);
        @(posedge clk); #1 data_o = 32'd0;
        @(negedge clk);
        chk("svc_ack_owner", {28'd0, ack}, {28'd0, g});
        @(negedge clk);
        chk("svc_post_ack_gnt", {24'd0, ack, gnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0]  g;
        logic [3:0]  exp_order[5];
        bit          any_ack;
        int          hit;

        vecs[0] = '{0, 1'b0, 32'h3300_1028, 32'h0000_0000, 32'h0000_00A5, 4'b0001, 32'h0000_00A5};
        vecs[1] = '{2, 1'b1, 32'h3300_0010, 32'hCAFE_0001, 32'hFFFF_FFFF, 4'b0100, 32'h0000_00A5};
        vecs[2] = '{3, 1'b0, 32'h3300_0ABC, 32'h0000_0000, 32'h1234_5678, 4'b1000, 32'h1234_5678};
        vecs[3] = '{1, 1'b0, 32'h3300_0004, 32'h0000_0000, 32'hDEAD_BEEF, 4'b0010, 32'hDEAD_BEEF};
        vecs[4] = '{1, 1'b1, 32'h3300_0020, 32'h55AA_55AA, 32'h0BAD_F00D, 4'b0010, 32'hDEAD_BEEF};
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;

        nrst      = 1'b0;
        req       = 4'd0;
        req_we    = 4'd0;
        req_addr  = '0;
        req_wdata = '0;
        busy_o    = 1'b0;
        data_o    = 32'd0;

        #2;
        chk("rst_gnt_ack", {24'd0, gnt, ack}, 32'd0);
        chk("rst_err_wr_rd", {29'd0, err, wr_en, r_en}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", addr, 32'h3300_0000);
        chk("rst_select_data", {select, data_i[27:0]}, 32'hF000_0000);
        @(posedge clk); #1 nrst = 1'b1;

        // Single transactions from the vector table.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_we    = 4'd0;
            req_addr  = {4{32'h3300_0F00}};
            req_wdata = {4{32'h1111_1111}};
            req       = 4'b0001 << vecs[i].idx;
            req_we[vecs[i].idx] = vecs[i].we;
            req_addr[vecs[i].idx*32 +: 32]  = vecs[i].a;
            req_wdata[vecs[i].idx*32 +: 32] = vecs[i].wd;
            @(negedge clk);
            chk("v_idle_gnt", {28'd0, gnt}, 32'd0);
            @(posedge clk); #1 req = 4'd0;
            @(negedge clk);
            chk("v_issue_gnt", {28'd0, gnt}, {28'd0, vecs[i].exp_gnt});
            chk("v_issue_strobes", {30'd0, wr_en, r_en}, {30'd0, vecs[i].we, !vecs[i].we});
            chk("v_issue_addr", addr, vecs[i].a);
            chk("v_issue_data_i", data_i, vecs[i].we ? vecs[i].wd : 32'd0);
            chk("v_issue_select", {28'd0, select}, 32'hF);
            @(posedge clk); #1 busy_o = 1'b1;
            @(negedge clk);
            chk("v_wacc_strobes", {30'd0, wr_en, r_en}, 32'd0);
            chk("v_wacc_addr", addr, vecs[i].a);
            @(posedge clk); #1 busy_o = 1'b0; data_o = vecs[i].sram;
            @(negedge clk);
            chk("v_wdone_ack", {28'd0, ack}, 32'd0);
            @(posedge clk); #1 data_o = 32'd0;
            @(negedge clk);
            chk("v_resp_ack", {28'd0, ack}, {28'd0, vecs[i].exp_gnt});
            chk("v_resp_rdata", rdata, vecs[i].exp_rdata);
            chk("v_resp_err", {31'd0, err}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("v_after_ack_gnt", {24'd0, ack, gnt}, 32'd0);
            chk("v_after_addr", addr, 32'h3300_0000);
        end

        // Requester 1 finished last, so the search starts at 2 and wraps to 0 before 1.
        @(posedge clk); #1 req = 4'b0011; req_we = 4'd0;
        service(32'h0000_0001, g);
        chk("rot_first_gnt", {28'd0, g}, 32'h1);
        service(32'h0000_0002, g);
        req = 4'd0;
        chk("rot_second_gnt", {28'd0, g}, 32'h2);
        chk("rot_rdata", rdata, 32'h0000_0002);

        // Reset while in WAIT_DONE: outputs drop at once, no ack, arbitration restarts at ptr 0.
        @(posedge clk); #1;
        req = 4'b0100; req_we = 4'd0; req_addr[95:64] = 32'h3300_0044;
        @(posedge clk); #1 req = 4'd0;
        @(posedge clk); #1 busy_o = 1'b1;
        @(posedge clk); #1;
        #2 nrst = 1'b0;
        #1;
        chk("rstmid_strobes", {30'd0, wr_en, r_en}, 32'd0);
        chk("rstmid_gnt_ack", {24'd0, gnt, ack}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        chk("rstmid_addr", addr, 32'h3300_0000);
        busy_o = 1'b0;
        @(posedge clk); #1 nrst = 1'b1;
        any_ack = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack != 4'd0) any_ack = 1'b1;
        end
        chk("rstmid_no_ack", {31'd0, any_ack}, 32'd0);
        @(posedge clk); #1 req = 4'b0110;
        service(32'h600D_0001, g);
        req = 4'd0;
        chk("rstmid_ptr_zero_gnt", {28'd0, g}, 32'h2);

        // Full contention held from reset.
        @(negedge clk);
        nrst = 1'b0; req = 4'b1111; req_we = 4'd0;
        @(posedge clk); #1 nrst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            service(32'hC0DE_0000 + 32'(n), g);
            chk("cont_gnt_order", {28'd0, g}, {28'd0, exp_order[n]});
        end
        req = 4'd0;
        chk("cont_rdata", rdata, 32'hC0DE_0004);

        // Stalled SRAM: busy_o never rises after ISSUE.
        @(posedge clk); #1;
        req = 4'b0001; req_we = 4'd0; req_addr[31:0] = 32'h3300_0100;
        @(posedge clk); #1 req = 4'd0;
        @(negedge clk);
        chk("tmo_issue_r_en", {31'd0, r_en}, 32'd1);
        hit = -1;
        for (int k = 0; k < 40 && hit < 0; k++) begin
            @(negedge clk);
            if (ack != 4'd0) hit = k;
        end
`ifdef T05_ARB_TIMEOUT_EN
        chk("tmo_ack_cycle", 32'(hit), 32'd16);
        chk("tmo_ack_owner", {28'd0, ack}, 32'h1);
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_rdata_kept", rdata, 32'hC0DE_0004);
        @(negedge clk);
        chk("tmo_err_clear", {27'd0, err, ack}, 32'd0);
`else
        chk("tmo_no_ack", 32'(hit), 32'hFFFF_FFFF);
        @(posedge clk); #1 busy_o = 1'b1;
        @(posedge clk); #1 busy_o = 1'b0; data_o = 32'h0000_0007;
        @(posedge clk); #1 data_o = 32'd0;
        @(negedge clk);
        chk("tmo_late_ack", {28'd0, ack}, 32'h1);
        chk("tmo_late_err", {31'd0, err}, 32'd0);
        chk("tmo_late_rdata", rdata, 32'h0000_0007);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/t05_sram_arbiter.md
T05_SRAM_ARBITER -- requirements
Module: t05_sram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, which sets the watchdog limit in cycles; it is used only when T05_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have req, input, 4 bits: per-requester request. Index 0 = histogram, 1 = FLV, 2 = HTREE, 3 = CB/TRN.
REQ-005 SHALL have req_we, input, 4 bits: per-requester write flag. 1 = write, 0 = read.
REQ-006 SHALL have req_addr, input, 128 bits: requester i byte address at bits [32i+31:32i].
REQ-007 SHALL have req_wdata, input, 128 bits: requester i write data at bits [32i+31:32i].
REQ-008 SHALL have gnt, output, 4 bits: one-hot owner of the current transaction.
REQ-009 SHALL have ack, output, 4 bits: one-cycle completion pulse to the owner.
REQ-010 SHALL have rdata, output, 32 bits: data from the last completed read.
REQ-011 SHALL have err, output, 1 bit: timeout flag, valid with ack.
REQ-012 SHALL have SRAM-side ports:
- wr_en, output, 1 bit
- r_en, output, 1 bit
- select, output, 4 bits
- addr, output, 32 bits
- data_i, output, 32 bits
- busy_o, input, 1 bit
- data_o, input, 32 bits

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESP; only one transaction is outstanding at a time.
REQ-014 IDLE: when any req bit is 1, SHALL select a winner round-robin, starting the search at index ptr.
- The winner's we, addr and wdata are latched.
- gnt is set one-hot to the winner.
- Next state is ISSUE.
- If no req bit is set, the FSM stays in IDLE.
REQ-015 ISSUE (exactly one cycle) SHALL drive:
- addr = latched address
- select = 4'hF
- wr_en = we and r_en = ~we
- data_i = wdata for writes, 0 for reads
- next state WAIT_ACC.
REQ-016 WAIT_ACC: wr_en and r_en SHALL be 0, addr and data_i held stable; on busy_o = 1 the FSM goes to WAIT_DONE.
REQ-017 WAIT_DONE: on busy_o = 0 the FSM SHALL go to RESP; for reads, data_o is captured into rdata on that edge.
REQ-018 RESP (one cycle) SHALL:
- assert ack of the winner
- clear gnt on exit
- set ptr = (winner + 1) mod 4
- go to IDLE.
REQ-019 Minimum latency: req sampled in IDLE at cycle N gives ISSUE at N+1 and ack at N+4, given busy_o high at N+2 and low at N+3.
REQ-020 Outside ISSUE/WAIT states the SRAM-side outputs SHALL be idle values: addr = 32'h33000000, data_i = 0, wr_en = 0, r_en = 0, select = 4'hF.
REQ-021 A requester dropping req after grant SHALL NOT abort the transaction; ack is still issued.
REQ-022 req is sampled only in IDLE; a requester that re-asserts req in its own RESP cycle competes in the next IDLE with its priority now lowest.
REQ-023 Writes SHALL leave rdata unchanged; rdata holds until the next read completes.
REQ-024 gnt and ack SHALL each be one-hot or zero at all times.

Reset
REQ-025 nrst low SHALL immediately force:
- state = IDLE, ptr = 0
- gnt = 0, ack = 0, err = 0, rdata = 0
- SRAM-side outputs to the REQ-020 idle values.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no ack; after release the arbiter re-arbitrates from ptr = 0.

Configuration
REQ-027 Macro T05_ARB_TIMEOUT_EN defined:
- A counter runs in WAIT_ACC and WAIT_DONE.
- After TIMEOUT_CYC cycles with no progress, the FSM goes to RESP with err = 1 during the ack cycle.
- rdata is unchanged on a timeout.
REQ-028 Macro T05_ARB_TIMEOUT_EN undefined: no counter; err is tied to 0 and the FSM waits on busy_o indefinitely; the port list is identical in both cases.

Verification
REQ-029 Single read: req = 4'b0001, req_addr[31:0] = 32'h33001028, req_we = 0; data_o = 32'h0000_00A5 when busy_o falls.
- Expect r_en pulsed 1 cycle with addr = 32'h33001028.
- Expect ack = 4'b0001 at N+4 and rdata = 32'h0000_00A5.
REQ-030 Single write: requester 2, addr 32'h33000010, wdata 32'hCAFE0001.
- Expect wr_en 1 cycle with data_i = 32'hCAFE0001.
- Expect ack = 4'b0100 and rdata unchanged.
REQ-031 Contention: req = 4'b1111 held continuously from reset. Expect grant order 0, 1, 2, 3, 0, with exactly one ack per transaction.
REQ-032 Priority rotation: requester 1 completes, then req = 4'b0011 is presented. Expect grant to index 0 first, since after ptr = 2 the search wraps and reaches 0 before 1.
REQ-033 Reset mid-op: nrst pulsed low while in WAIT_DONE. Expect wr_en, r_en, gnt and ack all 0 immediately, and no ack afterwards.
REQ-034 Timeout (T05_ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 16): busy_o held 0 after ISSUE. Expect ack with err = 1 exactly 16 cycles after WAIT_ACC entry; with the macro undefined, no ack occurs.
